osd_trace_overflow_buffer: RTL and testbench
============================================

// Module: osd_trace_overflow_buffer
//
// PURPOSE
//  Elastic FIFO in front of the trace packetizer. Absorbs bursty trace samples from a
//  trace generator that cannot stall. On FIFO overflow, drops and counts samples, then
//  emits one overflow record (trace_overflow=1, trace_data[9:0]=drop count). The record
//  is ordered after all samples accepted before the first drop. Output is the
//  trace_data/trace_overflow/trace_valid/trace_ready stream of the packetizer.
//
// PARAMETERS
//  WIDTH  16  trace sample width in bits; must be >= 10
//  DEPTH  8   FIFO entries; power of two, >= 2
//
// PORTS
//  clk             in   1            clock
//  rst             in   1            synchronous reset, active-high
//  sample_data     in   WIDTH        trace sample from generator
//  sample_valid    in   1            sample present; no backpressure to generator
//  trace_data      out  WIDTH        FIFO head, or {0, drop_count[9:0]} in overflow record
//  trace_overflow  out  1            1 = current output is an overflow record
//  trace_valid     out  1            output valid
//  trace_ready     in   1            consumer accepts output (handshake = valid & ready)
//  fill_level      out  $clog2(DEPTH)+1  entries stored     [OSD_TRACE_BUF_WATERMARK_EN only]
//  max_fill        out  $clog2(DEPTH)+1  high-water mark    [OSD_TRACE_BUF_WATERMARK_EN only]
//
// BEHAVIOUR
//  - Reset: FIFO empty, state NORMAL, drop_count=0, trace_valid=0, trace_overflow=0;
//    trace_data don't-care while !trace_valid.
//  - FIFO is first-word-fall-through. A sample written in cycle N is visible on
//    trace_data in cycle N+1. Read pops on handshake only.
//  - Full flag is evaluated before the same-cycle pop. A write while full is rejected
//    even if a pop happens that cycle.
//  - NORMAL state:
//    - sample_valid & !full -> write.
//    - sample_valid & full -> drop, drop_count=1, go to DRAIN.
//    - trace_valid = !empty; trace_overflow = 0.
//  - DRAIN state:
//    - Every sample_valid is dropped; drop_count++.
//    - Output continues presenting FIFO head.
//    - When FIFO is empty (after final pop) -> go to STATUS.
//  - STATUS state:
//    - trace_valid=1, trace_overflow=1, trace_data={0, drop_count}.
//    - Samples are dropped and counted while the record is not yet accepted.
//    - On handshake -> go to NORMAL, drop_count=0.
//    - A sample in the handshake cycle is written (FIFO empty), not counted.
//  - drop_count is 10 bits and saturates at 10'h3FF (no wrap).
//  - Output signals are stable while trace_valid & !trace_ready.
//  - Pointers wrap modulo DEPTH. The extra MSB distinguishes full from empty.
//  - Reset mid-operation discards FIFO contents and any pending drop count.
//
// CONFIGURATION
//  OSD_TRACE_BUF_WATERMARK_EN defined:
//    - Adds fill_level (current count) and max_fill.
//    - max_fill = running maximum of fill_level; reset to 0 by rst only.
//    - Both are registered and update the cycle after a push/pop.
//  Undefined: those ports and registers do not exist; datapath behaviour is identical.
//
// TESTING
//  1. Single sample 16'hABCD in cycle 0, trace_ready=1
//     -> trace_valid=1, trace_data=16'hABCD, trace_overflow=0 in cycle 1 only.
//  2. DEPTH=8, trace_ready=0, 8 samples 1..8
//     -> all stored, no drop; then ready=1 -> 1..8 emitted in order, no record.
//  3. DEPTH=8, ready=0, 11 samples, then ready=1
//     -> samples 1..8 emitted, then record trace_overflow=1, trace_data[9:0]=3.
//  4. Full FIFO, ready=0, 1100 samples
//     -> record reports 10'h3FF (saturated).
//  5. In STATUS, sample 16'h0055 in handshake cycle
//     -> record accepted with count unchanged; next output 16'h0055, trace_overflow=0.
//  6. rst asserted in DRAIN with 5 stored
//     -> next cycle trace_valid=0; no overflow record emitted afterwards.

Source files
------------

// File: rtl/osd_trace_overflow_buffer.sv
// -----------------------------------------------------------------------------
// osd_trace_overflow_buffer
//
// Elastic first-word-fall-through FIFO between a trace generator and the trace
// packetizer. The generator cannot be stalled. When the FIFO is full, incoming
// samples are dropped and counted. After every sample accepted before the
// first drop has been emitted, the buffer sends one overflow record:
// trace_overflow=1 and trace_data[9:0]=drop count.
//
// States:
//   NORMAL - samples are written while there is room.
//   DRAIN  - overflow seen; all samples are dropped and counted while the FIFO
//            empties toward the consumer.
//   STATUS - the overflow record is presented until the consumer accepts it.
//
// Optional feature macro: OSD_TRACE_BUF_WATERMARK_EN
//   When defined, fill_level (current occupancy) and max_fill (high-water mark)
//   are added as registered outputs. When undefined, those ports and registers
//   do not exist, and the datapath is unchanged.
// -----------------------------------------------------------------------------
module osd_trace_overflow_buffer #(
  parameter int WIDTH = 16,  // sample width, must be >= 10
  parameter int DEPTH = 8    // FIFO entries, power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sample_data,
  input  logic                     sample_valid,
  output logic [WIDTH-1:0]         trace_data,
  output logic                     trace_overflow,
  output logic                     trace_valid,
  input  logic                     trace_ready
`ifdef OSD_TRACE_BUF_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [$clog2(DEPTH):0]   max_fill
`endif
);

  localparam int AW = $clog2(DEPTH);  // address bits; pointers carry one extra wrap bit
  localparam int CW = 10;             // drop counter width

  localparam logic [CW-1:0] DROP_MAX = '1;
  localparam logic [AW:0]   ONE_ENTRY = (AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_DRAIN,
    ST_STATUS
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             full;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    drop_count;
  logic [CW-1:0]    drop_count_next;
  logic [CW-1:0]    drop_count_inc;

  logic             push;
  logic             pop;
  logic             drain_done;

  // Occupancy and flags derive from the pointers. The wrap bit tells full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // The drop counter holds at its maximum instead of wrapping to a small value.
  assign drop_count_inc = (drop_count == DROP_MAX) ? drop_count : drop_count + 10'd1;

  // A FIFO entry leaves only on a handshake while the FIFO head is on the output.
  // The overflow record is not a FIFO entry.
  assign pop = trace_valid && trace_ready && (state != ST_STATUS);

  // DRAIN ends once the FIFO is empty, counting the pop in this cycle.
  assign drain_done = empty || (pop && (count == ONE_ENTRY));

  // ---------------------------------------------------------------------------
  // State register, drop counter and pointers
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments, so every flop samples
  // the values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_NORMAL;
      drop_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_next;
      drop_count <= drop_count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage: write-only port. The read side is the combinational FIFO head.
  // NOTE: the memory array is not reset. Its contents are meaningless until
  // written, and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sample_data;
  end

  // ---------------------------------------------------------------------------
  // Next-state, write-enable and output decode
  // ---------------------------------------------------------------------------
  // Overflow FSM: decides accept/drop for each sample and what the consumer sees.
  // NOTE: every signal is given a default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    drop_count_next = drop_count;
    push            = 1'b0;
    trace_valid     = !empty;
    trace_overflow  = 1'b0;
    trace_data      = mem[rd_ptr[AW-1:0]];

    case (state)
      ST_NORMAL: begin
        // Fullness is taken before any pop in this cycle. A sample that meets a
        // full FIFO is dropped even if an entry leaves on the same edge.
        if (sample_valid) begin
          if (!full) begin
            push = 1'b1;
          end else begin
            drop_count_next = 10'd1;
            state_next      = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // No writes: every sample is dropped until the backlog has been emitted.
        // This keeps the record behind all samples that were accepted earlier.
        if (sample_valid) drop_count_next = drop_count_inc;
        if (drain_done)   state_next      = ST_STATUS;
      end

      ST_STATUS: begin
        trace_valid       = 1'b1;
        trace_overflow    = 1'b1;
        trace_data        = '0;
        trace_data[CW-1:0] = drop_count;
        if (trace_ready) begin
          // The record is accepted. The FIFO is empty, so a sample arriving in
          // the same cycle is stored and not counted.
          state_next      = ST_NORMAL;
          drop_count_next = '0;
          push            = sample_valid;
        end else if (sample_valid) begin
          // The record reports every drop up to its acceptance. Its count field
          // is the only output that may move while the record is stalled.
          drop_count_next = drop_count_inc;
        end
      end

      default: begin
        state_next = ST_NORMAL;
      end
    endcase
  end

`ifdef OSD_TRACE_BUF_WATERMARK_EN
  // ---------------------------------------------------------------------------
  // Fill-level monitor
  // ---------------------------------------------------------------------------
  logic [AW:0] wr_ptr_next;
  logic [AW:0] rd_ptr_next;
  logic [AW:0] fill_next;

  assign wr_ptr_next = push ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_next = pop  ? rd_ptr + 1'b1 : rd_ptr;
  assign fill_next   = wr_ptr_next - rd_ptr_next;

  // Occupancy and high-water mark are registered alongside the pointers.
  // Only reset lowers the high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_level <= '0;
      max_fill   <= '0;
    end else begin
      fill_level <= fill_next;
      if (fill_next > max_fill) max_fill <= fill_next;
    end
  end
`endif

endmodule

// File: tb/tb_osd_trace_overflow_buffer.sv
// -----------------------------------------------------------------------------
// tb_osd_trace_overflow_buffer
//
// Directed bench for osd_trace_overflow_buffer, default build (WIDTH=16, DEPTH=8).
// Inputs change, and outputs are observed, 2 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_osd_trace_overflow_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic [15:0] trace_data;
  logic        trace_overflow;
  logic        trace_valid;
  logic        trace_ready;

  int checks = 0;
  int errors = 0;

  osd_trace_overflow_buffer #(
    .WIDTH(16),
    .DEPTH(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Present n consecutive samples base, base+1, ... one per cycle.
  task automatic push_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = base + 16'(i);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  // With trace_ready high, expect n samples base, base+1, ... on consecutive cycles.
  task automatic drain_check(input string tag, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, {15'b0, trace_valid}, 16'h0001);
      check({tag, "_ovf"},   {15'b0, trace_overflow}, 16'h0000);
      check({tag, "_data"},  trace_data, base + 16'(i));
      tick();
    end
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    trace_ready  = 1'b0;
    tick();
    tick();
    check("reset_valid", {15'b0, trace_valid}, 16'h0000);
    check("reset_ovf",   {15'b0, trace_overflow}, 16'h0000);
    rst = 1'b0;
    tick();
    check("idle_valid", {15'b0, trace_valid}, 16'h0000);

    // 1: one sample, visible for exactly one cycle with ready high
    trace_ready  = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'hABCD;
    tick();
    sample_valid = 1'b0;
    check("t1_valid", {15'b0, trace_valid}, 16'h0001);
    check("t1_data",  trace_data, 16'hABCD);
    check("t1_ovf",   {15'b0, trace_overflow}, 16'h0000);
    tick();
    check("t1_gone", {15'b0, trace_valid}, 16'h0000);

    // 2: exactly DEPTH samples fill the FIFO without a drop
    trace_ready = 1'b0;
    push_n(8, 16'h0001);
    tick();
    check("t2_hold_data", trace_data, 16'h0001);
    trace_ready = 1'b1;
    drain_check("t2", 8, 16'h0001);
    check("t2_empty_valid", {15'b0, trace_valid}, 16'h0000);
    check("t2_no_record",   {15'b0, trace_overflow}, 16'h0000);

    // 3: 11 samples into 8 entries -> 1..8, then a record with count 3
    trace_ready = 1'b0;
    push_n(11, 16'h0001);
    trace_ready = 1'b1;
    drain_check("t3", 8, 16'h0001);
    check("t3_rec_valid", {15'b0, trace_valid}, 16'h0001);
    check("t3_rec_ovf",   {15'b0, trace_overflow}, 16'h0001);
    check("t3_rec_data",  trace_data, 16'h0003);
    tick();
    check("t3_after_valid", {15'b0, trace_valid}, 16'h0000);
    check("t3_after_ovf",   {15'b0, trace_overflow}, 16'h0000);

    // 4: 1100 drops saturate the count at 3FF; a stalled record holds steady
    trace_ready = 1'b0;
    push_n(8 + 1100, 16'h0100);
    trace_ready = 1'b1;
    drain_check("t4", 8, 16'h0100);
    check("t4_rec_ovf",  {15'b0, trace_overflow}, 16'h0001);
    check("t4_rec_data", trace_data, 16'h03FF);
    trace_ready = 1'b0;
    tick();
    tick();
    check("t4_stall_valid", {15'b0, trace_valid}, 16'h0001);
    check("t4_stall_ovf",   {15'b0, trace_overflow}, 16'h0001);
    check("t4_stall_data",  trace_data, 16'h03FF);
    trace_ready = 1'b1;
    tick();
    check("t4_after_valid", {15'b0, trace_valid}, 16'h0000);

    // Full FIFO with a pop and a sample in the same cycle: the sample is dropped
    trace_ready = 1'b0;
    push_n(8, 16'h0020);
    trace_ready  = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'h0077;
    tick();
    sample_valid = 1'b0;
    drain_check("fp", 7, 16'h0021);
    check("fp_rec_ovf",  {15'b0, trace_overflow}, 16'h0001);
    check("fp_rec_data", trace_data, 16'h0001);

    // 5: a sample in the record handshake cycle is stored, not counted
    sample_valid = 1'b1;
    sample_data  = 16'h0055;
    tick();
    sample_valid = 1'b0;
    check("t5_valid", {15'b0, trace_valid}, 16'h0001);
    check("t5_ovf",   {15'b0, trace_overflow}, 16'h0000);
    check("t5_data",  trace_data, 16'h0055);
    tick();
    check("t5_empty", {15'b0, trace_valid}, 16'h0000);

    // 6: reset in DRAIN with 5 stored discards everything, including the record
    trace_ready = 1'b0;
    push_n(9, 16'h0030);
    trace_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t6_pre_data", trace_data, 16'h0033);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", {15'b0, trace_valid}, 16'h0000);
    check("t6_rst_ovf",   {15'b0, trace_overflow}, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t6_quiet_valid", {15'b0, trace_valid}, 16'h0000);
      check("t6_quiet_ovf",   {15'b0, trace_overflow}, 16'h0000);
    end
    push_n(1, 16'h1234);
    check("t6_resume_valid", {15'b0, trace_valid}, 16'h0001);
    check("t6_resume_data",  trace_data, 16'h1234);
    check("t6_resume_ovf",   {15'b0, trace_overflow}, 16'h0000);
    tick();
    check("t6_resume_empty", {15'b0, trace_valid}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
